// File: rtl/trail_writer.sv
// trail_writer
//   Write-side stage for the 640x480 frame buffer (one 16-bit word per
//   horizontal pixel pair: even pixel in [3:0], odd pixel in [11:8],
//   address = X/2 + Y*320).
//   On every rising edge of frame_clk it stamps a STAMP_WORDS x STAMP_ROWS
//   block for the blue bike, then for the red bike. On start_clear it
//   writes BG_COLOR to all 153600 words.
//
// Ports
//   Clk            system clock
//   Reset          synchronous, active-low reset
//   frame_clk      frame tick level, synchronous to Clk
//   start_clear    one-cycle request for a full-buffer clear
//   blue_en/red_en bike alive flags, latched on the frame edge
//   *_X_real/*_Y_real  stamp anchors in pixels, latched on the frame edge
//   WE, write_address, Data_In  frame RAM write port (all registered)
//   busy           high whenever the FSM is not IDLE
//   clear_done     one-cycle pulse as a clear finishes
//   overrun        sticky: a frame edge arrived while busy
//   state_o        current FSM state (debug)
//
// Handshake: there is no backpressure. A request (frame edge or
// start_clear) is taken only in IDLE; anything arriving otherwise is
// dropped, and a dropped frame edge sets overrun.
module trail_writer #(
  parameter int          STAMP_WORDS = 2,
  parameter int          STAMP_ROWS  = 2,
  parameter logic [3:0]  BLUE_TRAIL  = 4'h6,
  parameter logic [3:0]  RED_TRAIL   = 4'h4,
  parameter logic [3:0]  BG_COLOR    = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start_clear,
  input  logic        blue_en,
  input  logic        red_en,
  input  logic [9:0]  Blue_X_real,
  input  logic [9:0]  Blue_Y_real,
  input  logic [9:0]  Red_X_real,
  input  logic [9:0]  Red_Y_real,
  output logic        WE,
  output logic [18:0] write_address,
  output logic [15:0] Data_In,
  output logic        busy,
  output logic        clear_done,
  output logic        overrun,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    STAMP_B = 2'd2,
    STAMP_R = 2'd3
  } state_t;

  localparam int WW = (STAMP_WORDS > 1) ? $clog2(STAMP_WORDS) : 1;
  localparam int RW = (STAMP_ROWS  > 1) ? $clog2(STAMP_ROWS)  : 1;
  localparam logic [WW-1:0] W_LAST     = WW'(STAMP_WORDS - 1);
  localparam logic [RW-1:0] R_LAST     = RW'(STAMP_ROWS - 1);
  localparam logic [17:0]   CLEAR_LAST = 18'd153599;

  state_t        state_q, state_d;
  logic [17:0]   cnt_q, cnt_d;
  logic [WW-1:0] w_q, w_d;
  logic [RW-1:0] r_q, r_d;
  logic [8:0]    bx_q, bx_d, rx_q, rx_d;   // anchor X already halved to a word column
  logic [9:0]    by_q, by_d, ry_q, ry_d;
  logic          ben_q, ben_d, ren_q, ren_d;
  logic          fc_q;
  logic          overrun_q, overrun_d;
  logic          we_q, we_d;
  logic [18:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rise;

  // Stamp slot helpers
  logic [8:0]    s_x;
  logic [9:0]    s_y;
  logic          s_en;
  logic [3:0]    s_col;
  logic [18:0]   s_c, s_row, s_addr;

  // Anchor X is rounded down to even, so its LSB never matters.
  logic          unused_xlsb;
  assign unused_xlsb = Blue_X_real[0] ^ Red_X_real[0];

  assign rise = frame_clk & ~fc_q;

  // State register (also holds the registered outputs)
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      w_q       <= '0;
      r_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      ben_q     <= 1'b0;
      ren_q     <= 1'b0;
      fc_q      <= 1'b0;
      overrun_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      r_q       <= r_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      ben_q     <= ben_d;
      ren_q     <= ren_d;
      fc_q      <= frame_clk;
      overrun_q <= overrun_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    r_d       = r_q;
    bx_d      = bx_q;
    by_d      = by_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    ben_d     = ben_q;
    ren_d     = ren_q;
    overrun_d = overrun_q;

    if (state_q != IDLE && rise) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        // Clear has priority; a rise in the same cycle is simply dropped.
        if (start_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (rise) begin
          state_d = STAMP_B;
          w_d     = '0;
          r_d     = '0;
          bx_d    = Blue_X_real[9:1];
          by_d    = Blue_Y_real;
          rx_d    = Red_X_real[9:1];
          ry_d    = Red_Y_real;
          ben_d   = blue_en;
          ren_d   = red_en;
        end
      end
      CLEAR: begin
        if (cnt_q == CLEAR_LAST) state_d = IDLE;
        else                     cnt_d   = cnt_q + 18'd1;
      end
      STAMP_B, STAMP_R: begin
        if (w_q == W_LAST) begin
          w_d = '0;
          if (r_q == R_LAST) begin
            r_d     = '0;
            state_d = (state_q == STAMP_B) ? STAMP_R : IDLE;
          end else begin
            r_d = r_q + RW'(1);
          end
        end else begin
          w_d = w_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: evaluated on the slot about to be entered so that the
  // registered write lands the cycle after the request is accepted.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    busy_d = (state_d != IDLE);
    done_d = (state_q == CLEAR) && (state_d == IDLE);

    if (state_d == STAMP_B) begin
      s_x   = bx_d;
      s_y   = by_d;
      s_en  = ben_d;
      s_col = BLUE_TRAIL;
    end else begin
      s_x   = rx_d;
      s_y   = ry_d;
      s_en  = ren_d;
      s_col = RED_TRAIL;
    end
    s_c    = 19'(s_x) + 19'(w_d);
    s_row  = 19'(s_y) + 19'(r_d);
    s_addr = s_c + s_row * 19'd320;

    case (state_d)
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = {1'b0, cnt_d};
        data_d = {4'h0, BG_COLOR, 4'h0, BG_COLOR};
      end
      STAMP_B, STAMP_R: begin
        // Off-screen slots still take their cycle but write nothing.
        if (s_en && (s_c <= 19'd319) && (s_row <= 19'd479)) begin
          we_d   = 1'b1;
          addr_d = s_addr;
          data_d = {4'h0, s_col, 4'h0, s_col};
        end
      end
      default: ;
    endcase
  end

  assign WE            = we_q;
  assign write_address = addr_q;
  assign Data_In       = data_q;
  assign busy          = busy_q;
  assign clear_done    = done_q;
  assign overrun       = overrun_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_trail_writer.sv
module tb_trail_writer;

  localparam int SW = 2;
  localparam int SR = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic        start_clear = 1'b0;
  logic        blue_en = 1'b0;
  logic        red_en = 1'b0;
  logic [9:0]  Blue_X_real = '0;
  logic [9:0]  Blue_Y_real = '0;
  logic [9:0]  Red_X_real = '0;
  logic [9:0]  Red_Y_real = '0;
  logic        WE;
  logic [18:0] write_address;
  logic [15:0] Data_In;
  logic        busy;
  logic        clear_done;
  logic        overrun;
  logic [1:0]  state_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: expected {WE, address, data} per stamp slot,
  // plus the last written address/data (held on non-write slots).
  logic [35:0] exp_q[$];
  logic [18:0] m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_overrun = 1'b0;

  trail_writer dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_clear(start_clear),
    .blue_en(blue_en), .red_en(red_en),
    .Blue_X_real(Blue_X_real), .Blue_Y_real(Blue_Y_real),
    .Red_X_real(Red_X_real), .Red_Y_real(Red_Y_real),
    .WE(WE), .write_address(write_address), .Data_In(Data_In),
    .busy(busy), .clear_done(clear_done), .overrun(overrun), .state_o(state_o)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: blue block then red block, row-major, clipped to 320x480 words.
  task automatic model_stamp(input logic [9:0] bx, input logic [9:0] by,
                             input logic [9:0] rx, input logic [9:0] ry,
                             input logic ben, input logic ren);
    for (int bike = 0; bike < 2; bike++) begin
      int ax = (bike == 0) ? int'(bx) : int'(rx);
      int ay = (bike == 0) ? int'(by) : int'(ry);
      logic en = (bike == 0) ? ben : ren;
      logic [3:0] col = (bike == 0) ? 4'h6 : 4'h4;
      for (int r = 0; r < SR; r++) begin
        for (int w = 0; w < SW; w++) begin
          int c = ax / 2 + w;
          int y = ay + r;
          if (en && c < 320 && y < 480) begin
            m_addr = 19'(c + y * 320);
            m_data = {4'h0, col, 4'h0, col};
            exp_q.push_back({1'b1, m_addr, m_data});
          end else begin
            exp_q.push_back({1'b0, m_addr, m_data});
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      frame_clk = ~frame_clk;
    end
    @(negedge Clk);
    vectors++;
    if ({WE, write_address, Data_In, busy, clear_done, overrun} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got WE=%b addr=%0d data=%h busy=%b done=%b ovr=%b, want all 0",
               WE, write_address, Data_In, busy, clear_done, overrun);
    end
    vectors++;
    if (state_o !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d want 0 (IDLE)", state_o);
    end
    frame_clk = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    vectors++;
    if (WE !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got WE=%b busy=%b want 0 0", WE, busy);
    end
  endtask

  // Clear requested together with a frame rise: the clear runs, the rise
  // is lost and overrun stays 0. A second start_clear mid-clear is ignored.
  task automatic test_clear_with_rise();
    int bad = 0;
    int first_bad = -1;
    @(negedge Clk);
    frame_clk = 1'b0;
    start_clear = 1'b0;
    @(negedge Clk);
    start_clear = 1'b1;
    frame_clk = 1'b1;
    for (int i = 0; i < 153600; i++) begin
      @(negedge Clk);
      start_clear = (i == 1000);
      if (WE !== 1'b1 || write_address !== 19'(i) || Data_In !== 16'h0000 ||
          busy !== 1'b1 || clear_done !== 1'b0) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL clear_seq: %0d bad cycles, first at slot %0d, want 0 bad cycles", bad, first_bad);
    end
    @(negedge Clk);
    vectors++;
    if (WE !== 1'b0 || clear_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_end: got WE=%b done=%b busy=%b want 0 1 0", WE, clear_done, busy);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_no_overrun: got %b want 0", overrun);
    end
    @(negedge Clk);
    vectors++;
    if (clear_done !== 1'b0 || WE !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_done_pulse: got done=%b WE=%b busy=%b want 0 0 0", clear_done, WE, busy);
    end
    m_addr = 19'd153599;
    m_data = 16'h0000;
    frame_clk = 1'b0;
  endtask

  // One frame: rise_at >= 1 injects a second rise at that slot,
  // clr_at >= 0 pulses start_clear at that slot; coordinates are
  // scrambled during the stamp.
  task automatic run_stamp(input logic [9:0] bx, input logic [9:0] by,
                           input logic [9:0] rx, input logic [9:0] ry,
                           input logic ben, input logic ren,
                           input int rise_at, input int clr_at);
    logic [35:0] e;
    @(negedge Clk);
    frame_clk = 1'b0;
    start_clear = 1'b0;
    @(negedge Clk);
    Blue_X_real = bx; Blue_Y_real = by; Red_X_real = rx; Red_Y_real = ry;
    blue_en = ben; red_en = ren;
    frame_clk = 1'b1;
    model_stamp(bx, by, rx, ry, ben, ren);
    for (int k = 0; k < 2 * SW * SR; k++) begin
      @(negedge Clk);
      e = exp_q.pop_front();
      vectors++;
      if ({WE, write_address, Data_In} !== e) begin
        miscompares++;
        $display("FAIL stamp_slot%0d: got WE=%b addr=%0d data=%h want WE=%b addr=%0d data=%h",
                 k, WE, write_address, Data_In, e[35], e[34:16], e[15:0]);
      end
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL stamp_busy%0d: got %b want 1", k, busy);
      end
      Blue_X_real = 10'($urandom); Blue_Y_real = 10'($urandom);
      Red_X_real = 10'($urandom); Red_Y_real = 10'($urandom);
      blue_en = 1'($urandom); red_en = 1'($urandom);
      if (k == 0) frame_clk = 1'b0;
      if (rise_at >= 1 && k == rise_at) begin
        frame_clk = 1'b1;
        m_overrun = 1'b1;
      end
      start_clear = (k == clr_at);
    end
    @(negedge Clk);
    start_clear = 1'b0;
    frame_clk = 1'b0;
    vectors++;
    if (WE !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stamp_end: got WE=%b busy=%b want 0 0", WE, busy);
    end
    vectors++;
    if (overrun !== m_overrun) begin
      miscompares++;
      $display("FAIL stamp_overrun: got %b want %b", overrun, m_overrun);
    end
    @(negedge Clk);
    vectors++;
    if (WE !== 1'b0 || busy !== 1'b0 || write_address !== m_addr || Data_In !== m_data) begin
      miscompares++;
      $display("FAIL stamp_idle_hold: got WE=%b busy=%b addr=%0d data=%h want 0 0 %0d %h",
               WE, busy, write_address, Data_In, m_addr, m_data);
    end
  endtask

  task automatic test_blue_only();
    run_stamp(10'd100, 10'd50, 10'd300, 10'd200, 1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_red_corner();
    run_stamp(10'd20, 10'd20, 10'd639, 10'd479, 1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_overrun();
    run_stamp(10'd101, 10'd50, 10'd200, 10'd300, 1'b1, 1'b1, 3, 1);
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 24; n++) begin
      logic [9:0] bx, by, rx, ry;
      bx = $urandom_range(0, 1) ? 10'($urandom_range(0, 639)) : 10'($urandom_range(600, 1023));
      by = $urandom_range(0, 1) ? 10'($urandom_range(0, 479)) : 10'($urandom_range(460, 1023));
      rx = $urandom_range(0, 1) ? 10'($urandom_range(0, 639)) : 10'($urandom_range(600, 1023));
      ry = $urandom_range(0, 1) ? 10'($urandom_range(0, 479)) : 10'($urandom_range(460, 1023));
      run_stamp(bx, by, rx, ry, 1'($urandom), 1'($urandom),
                (n % 5 == 0) ? int'($urandom_range(1, 7)) : -1,
                (n % 3 == 0) ? int'($urandom_range(0, 7)) : -1);
    end
  endtask

  task automatic test_reset_mid_clear();
    @(negedge Clk);
    start_clear = 1'b1;
    @(negedge Clk);
    start_clear = 1'b0;
    repeat (50) @(negedge Clk);
    vectors++;
    if (WE !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midclear_running: got WE=%b busy=%b want 1 1", WE, busy);
    end
    Reset = 1'b0;
    @(negedge Clk);
    vectors++;
    if (WE !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || write_address !== 19'd0 || state_o !== 2'd0) begin
      miscompares++;
      $display("FAIL midclear_reset: got WE=%b busy=%b ovr=%b addr=%0d state=%0d want 0 0 0 0 0",
               WE, busy, overrun, write_address, state_o);
    end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    vectors++;
    if (WE !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midclear_stays_idle: got WE=%b busy=%b done=%b want 0 0 0", WE, busy, clear_done);
    end
  endtask

  initial begin
    test_reset();
    test_clear_with_rise();
    test_blue_only();
    test_red_corner();
    test_overrun();
    test_random_frames();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trail_writer.md
Name: trail_writer

Overview:
- Upstream write-side stage for the 640x480 frame buffer consumed by the per-pixel colour/compositing stage.
- On each new frame (rising edge of frame_clk), stamps a small trail block for the blue and red bikes into frame RAM through its single write port.
- Also runs a full-screen clear to the background colour on request, at game start or restart.
- Buffer word format: one 16-bit word per horizontal pixel pair; even pixel in [3:0], odd pixel in [11:8], all other bits 0; address = (X/2) + Y*320.

Parameters:
STAMP_WORDS, 2, stamp width in words (2 pixels per word)
STAMP_ROWS, 2, stamp height in rows
BLUE_TRAIL, 4'h6, blue trail colour enum
RED_TRAIL, 4'h4, red trail colour enum
BG_COLOR, 4'h0, background colour enum used by clear

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
frame_clk  in  1  frame tick (~60 Hz), synchronous to Clk, level signal
start_clear  in  1  one-cycle request to clear the whole buffer
blue_en  in  1  blue bike alive; stamp blue this frame
red_en  in  1  red bike alive; stamp red this frame
Blue_X_real  in  10  blue stamp anchor X (pixel)
Blue_Y_real  in  10  blue stamp anchor Y
Red_X_real  in  10  red stamp anchor X
Red_Y_real  in  10  red stamp anchor Y
WE  out  1  frame RAM write enable
write_address  out  19  frame RAM word address
Data_In  out  16  frame RAM write data
busy  out  1  high whenever not in IDLE
clear_done  out  1  one-cycle pulse when clear completes
overrun  out  1  sticky: a frame edge arrived while busy

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (Reset=0 at a Clk edge): state=IDLE; WE, write_address, Data_In, busy, clear_done, overrun all 0; frame_clk history register cleared.
- Reset mid-operation aborts immediately; the partially written buffer is left as is.
- All outputs are registered.
- Frame edge detect: fc_d <= frame_clk each cycle; rise = frame_clk & ~fc_d.
- States: IDLE, CLEAR, STAMP_B, STAMP_R.
- IDLE:
  - start_clear=1 -> CLEAR. Clear wins over a simultaneous rise; that rise is discarded and overrun is not set.
  - Else rise=1 -> latch all four coordinates and both enables -> STAMP_B.
- CLEAR:
  - One write per cycle; addresses 0..153599 ascending; Data_In={4'h0,BG_COLOR,4'h0,BG_COLOR}; WE=1.
  - First write appears the cycle after the request is accepted.
  - After address 153599, clear_done pulses for 1 cycle concurrent with the return to IDLE.
  - start_clear during CLEAR is ignored.
- STAMP_B / STAMP_R:
  - Exactly STAMP_WORDS*STAMP_ROWS cycles each, row-major: row r=0..STAMP_ROWS-1, word w=0..STAMP_WORDS-1.
  - Target column c = X[9:1] + w; target row y = Y + r.
  - write_address = c + y*320, computed at 19-bit width with no truncation.
  - Data_In = {4'h0,col,4'h0,col}, where col is BLUE_TRAIL or RED_TRAIL.
  - Anchor X is rounded down to even (X[0] ignored).
  - WE=1 only if the latched enable is 1, c<=319, and y<=479. Otherwise WE=0 for that slot and write_address/Data_In hold their previous values; the slot still consumes its cycle.
  - Fixed latency: first blue slot the cycle after rise; red begins immediately after the last blue slot; return to IDLE after 2*STAMP_WORDS*STAMP_ROWS slots.
- A rise while not in IDLE is dropped and sets overrun=1, which stays set until reset. start_clear while stamping is dropped (not queued).
- busy=1 for every cycle the state is not IDLE. WE=0 in IDLE.
- Coordinates changing during a stamp have no effect; the latched copies are used.

Test Plan:
- Reset=0 for 2 cycles while frame_clk toggles -> all outputs 0, state IDLE, no WE.
- start_clear pulse -> exactly 153600 consecutive WE=1 cycles, addresses 0..153599, Data_In=16'h0000; clear_done single pulse; busy then low.
- Blue (100,50) en, red_en=0, frame rise -> blue writes at 16050, 16051, 16370, 16371 with data 16'h0606; then 4 red slots with WE=0; busy high for 8 cycles.
- Red (639,479) en, blue_en=0 -> exactly one write at 153599 with data 16'h0404; the 3 clipped red slots have WE=0.
- Second frame rise 3 cycles into stamping -> ignored, overrun=1 and stays 1; stamp sequence unchanged.
- start_clear and rise in the same IDLE cycle -> clear runs, no stamp, overrun=0. Reset asserted mid-clear -> WE=0 next cycle, IDLE.
